servo_sequencer: RTL

Bus-mapped controller that drives the servo PWM peripheral through its memory-bus slave port. It holds an 8-entry position/dwell program and, when running, writes each position to the servo's selector register in turn, then waits a programmed dwell before the next step. It sits between the CPU data bus (as a slave) and the servo (as sole bus master). The CPU programs and starts it, then is free.

---
 rtl/servo_seq_pkg.sv | 53 +++++
 rtl/servo_seq_timer.sv | 60 ++++++
 rtl/servo_sequencer.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/servo_seq_pkg.sv
// Shared types and constants for the servo position sequencer.
package servo_seq_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StLoad,
        StWrite,
        StDwell
    } seq_state_e;

    // Word offsets decoded from address_in[5:2]
    localparam logic [3:0] OffCtrl   = 4'd0;
    localparam logic [3:0] OffStatus = 4'd1;
    // PROG[i] occupies offsets 8..15: offset bit 3 set, low three bits select the entry
    localparam int unsigned OffProgBit = 3;

    // CTRL fields
    localparam int unsigned CtrlRunBit  = 0;
    localparam int unsigned CtrlLoopBit = 1;
    localparam int unsigned CtrlLastLsb = 8;

    // STATUS fields
    localparam int unsigned StatusBusyBit = 0;
    localparam int unsigned StatusIdxLsb  = 8;
    localparam int unsigned StatusDoneBit = 16;

    // PROG fields
    localparam int unsigned ProgPosLsb   = 0;
    localparam int unsigned ProgDwellLsb = 16;

    localparam int unsigned PosWidth   = 8;
    localparam int unsigned DwellWidth = 12;
    localparam int unsigned IdxWidth   = 3;
    localparam int unsigned NumEntries = 8;

    // Servo selector register is a single byte
    localparam logic [3:0] ServoWriteMask = 4'b0001;

    // Byte-lane merge of a bus write into an existing register image
    function automatic logic [31:0] merge_bytes(input logic [31:0] cur,
                                                input logic [31:0] wdata,
                                                input logic [3:0]  mask);
        logic [31:0] res;
        res = cur;
        for (int b = 0; b < 4; b++) begin
            if (mask[b]) begin
                res[8*b +: 8] = wdata[8*b +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/servo_seq_timer.sv
// Dwell timer: a prescaler wrapping every TICK_CYCLES clocks feeding a tick
// down-counter. done pulses on the final clock of the programmed dwell.
module servo_seq_timer
    import servo_seq_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 12000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  load,
    input  logic [DwellWidth-1:0] dwell,
    input  logic                  enable,
    output logic                  done
);

    localparam int unsigned PreWidth = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
    localparam logic [PreWidth-1:0] PreMax = PreWidth'(TICK_CYCLES - 1);

    logic [PreWidth-1:0]   pre_q, pre_d;
    logic [DwellWidth-1:0] tick_q, tick_d;
    logic                  wrap;

    // Prescaler wrap and end-of-dwell detection
    always_comb begin
        wrap = enable && (pre_q == PreMax);
        // tick of 1 at the wrap means this is the last clock of the dwell
        done = wrap && (tick_q <= DwellWidth'(1));
    end

    // Next-state for prescaler and tick counter
    always_comb begin
        pre_d  = pre_q;
        tick_d = tick_q;
        if (load) begin
            pre_d  = '0;
            tick_d = dwell;
        end else if (enable) begin
            if (wrap) begin
                pre_d = '0;
                if (tick_q != '0) begin
                    tick_d = tick_q - DwellWidth'(1);
                end
            end else begin
                pre_d = pre_q + PreWidth'(1);
            end
        end
    end

    // Counter state
    always_ff @(posedge clk) begin
        if (reset) begin
            pre_q  <= '0;
            tick_q <= '0;
        end else begin
            pre_q  <= pre_d;
            tick_q <= tick_d;
        end
    end

endmodule

// File: rtl/servo_sequencer.sv
// Bus-mapped servo sequencer: steps through an 8-entry position/dwell program,
// writing each position to the servo peripheral and waiting the dwell between.
module servo_sequencer
    import servo_seq_pkg::*;
#(
    parameter int unsigned TICK_CYCLES = 12000,
    parameter logic [31:0] SERVO_ADDR  = 32'h0000_0000,
    parameter int unsigned MAX_POS     = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address_in,
    input  logic        sel_in,
    input  logic        read_in,
    output logic [31:0] read_value_out,
    input  logic [3:0]  write_mask_in,
    input  logic [31:0] write_value_in,
    output logic        ready_out,
    output logic [31:0] servo_address_out,
    output logic        servo_sel_out,
    output logic [3:0]  servo_write_mask_out,
    output logic [31:0] servo_write_value_out,
    input  logic        servo_ready_in,
    output logic        busy,
    output logic [2:0]  step_monitor
);

    localparam logic [PosWidth-1:0] MaxPos = PosWidth'(MAX_POS);

    seq_state_e state_q, state_d;

    logic                run_q, run_d;
    logic                loop_q, loop_d;
    logic [IdxWidth-1:0] last_q, last_d;
    logic                done_q, done_d;
    logic [IdxWidth-1:0] idx_q, idx_d;

    logic [PosWidth-1:0]   prog_pos_q   [NumEntries];
    logic [DwellWidth-1:0] prog_dwell_q [NumEntries];

    logic [PosWidth-1:0]   pos_q;
    logic [DwellWidth-1:0] dwell_q;
    logic [31:0]           read_value_q;

    logic [3:0]          offset;
    logic                wr_en, rd_en, ctrl_wr, prog_wr;
    logic [IdxWidth-1:0] prog_sel;
    logic [31:0]         ctrl_img, status_img, prog_img, rd_data;
    logic [31:0]         ctrl_new, prog_new;
    logic                run_eff;

    logic ev_start, ev_load, ev_wr_done, ev_next, ev_wrap, ev_finish;
    logic tmr_done;

    logic unused_bits;
    assign unused_bits = ^{address_in[31:6], address_in[1:0], ctrl_new[31:11],
                           ctrl_new[7:2], prog_new[31:28], prog_new[15:8]};

    assign offset   = address_in[5:2];
    assign wr_en    = sel_in && (write_mask_in != 4'b0000);
    assign rd_en    = sel_in && read_in;
    assign ctrl_wr  = wr_en && (offset == OffCtrl);
    assign prog_wr  = wr_en && offset[OffProgBit];
    assign prog_sel = offset[IdxWidth-1:0];

    // Register images as seen by the CPU, and the result of merging a write
    always_comb begin
        ctrl_img = '0;
        ctrl_img[CtrlRunBit] = run_q;
        ctrl_img[CtrlLoopBit] = loop_q;
        ctrl_img[CtrlLastLsb +: IdxWidth] = last_q;

        status_img = '0;
        status_img[StatusBusyBit] = (state_q != StIdle);
        status_img[StatusIdxLsb +: IdxWidth] = idx_q;
        status_img[StatusDoneBit] = done_q;

        prog_img = '0;
        prog_img[ProgPosLsb +: PosWidth] = prog_pos_q[prog_sel];
        prog_img[ProgDwellLsb +: DwellWidth] = prog_dwell_q[prog_sel];

        ctrl_new = merge_bytes(ctrl_img, write_value_in, write_mask_in);
        prog_new = merge_bytes(prog_img, write_value_in, write_mask_in);

        // A CPU write to RUN takes effect for the FSM in the same cycle
        run_eff = ctrl_wr ? ctrl_new[CtrlRunBit] : run_q;
    end

    // Read data mux; unmapped offsets read as zero
    always_comb begin
        rd_data = '0;
        if (offset == OffCtrl) begin
            rd_data = ctrl_img;
        end else if (offset == OffStatus) begin
            rd_data = status_img;
        end else if (offset[OffProgBit]) begin
            rd_data = prog_img;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state and sequencing events
    always_comb begin
        state_d    = state_q;
        ev_start   = 1'b0;
        ev_load    = 1'b0;
        ev_wr_done = 1'b0;
        ev_next    = 1'b0;
        ev_wrap    = 1'b0;
        ev_finish  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (run_eff) begin
                    state_d  = StLoad;
                    ev_start = 1'b1;
                end
            end
            StLoad: begin
                if (!run_eff) begin
                    state_d = StIdle;
                end else begin
                    state_d = StWrite;
                    ev_load = 1'b1;
                end
            end
            StWrite: begin
                // A started write always completes, even if RUN was cleared
                if (servo_ready_in) begin
                    ev_wr_done = 1'b1;
                    state_d    = run_eff ? StDwell : StIdle;
                end
            end
            StDwell: begin
                if (!run_eff) begin
                    state_d = StIdle;
                end else if (tmr_done) begin
                    if (idx_q == last_q) begin
                        if (loop_q) begin
                            ev_wrap = 1'b1;
                            state_d = StLoad;
                        end else begin
                            ev_finish = 1'b1;
                            state_d   = StIdle;
                        end
                    end else begin
                        ev_next = 1'b1;
                        state_d = StLoad;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FSM outputs
    always_comb begin
        busy                 = (state_q != StIdle);
        servo_sel_out        = 1'b0;
        servo_write_mask_out = 4'b0000;
        if (state_q == StWrite) begin
            servo_sel_out        = 1'b1;
            servo_write_mask_out = ServoWriteMask;
        end
    end

    // Control/status next state: CPU writes, step index, sticky DONE
    always_comb begin
        run_d  = run_eff;
        loop_d = loop_q;
        last_d = last_q;
        done_d = done_q;
        idx_d  = idx_q;
        if (ctrl_wr) begin
            loop_d = ctrl_new[CtrlLoopBit];
            last_d = ctrl_new[CtrlLastLsb +: IdxWidth];
            done_d = 1'b0;
        end
        // Auto-clear of RUN loses to a simultaneous CPU write of RUN
        if (ev_finish && !(ctrl_wr && write_mask_in[0])) begin
            run_d = 1'b0;
        end
        if (ev_start || ev_wrap) begin
            idx_d = '0;
        end
        if (ev_start) begin
            done_d = 1'b0;
        end
        if (ev_next) begin
            idx_d = idx_q + IdxWidth'(1);
        end
        if (ev_finish) begin
            done_d = 1'b1;
        end
    end

    // Control/status registers
    always_ff @(posedge clk) begin
        if (reset) begin
            run_q  <= 1'b0;
            loop_q <= 1'b0;
            last_q <= '0;
            done_q <= 1'b0;
            idx_q  <= '0;
        end else begin
            run_q  <= run_d;
            loop_q <= loop_d;
            last_q <= last_d;
            done_q <= done_d;
            idx_q  <= idx_d;
        end
    end

    // Program memory; entries may be rewritten while the sequencer runs
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NumEntries; i++) begin
                prog_pos_q[i]   <= '0;
                prog_dwell_q[i] <= '0;
            end
        end else if (prog_wr) begin
            prog_pos_q[prog_sel]   <= prog_new[ProgPosLsb +: PosWidth];
            prog_dwell_q[prog_sel] <= prog_new[ProgDwellLsb +: DwellWidth];
        end
    end

    // Latch current step: position clamped to MAX_POS, zero dwell runs as one tick
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q   <= '0;
            dwell_q <= '0;
        end else if (ev_load) begin
            pos_q   <= (prog_pos_q[idx_q] > MaxPos) ? MaxPos : prog_pos_q[idx_q];
            dwell_q <= (prog_dwell_q[idx_q] == '0) ? DwellWidth'(1) : prog_dwell_q[idx_q];
        end
    end

    // Registered read data, updated only on a read strobe
    always_ff @(posedge clk) begin
        if (reset) begin
            read_value_q <= '0;
        end else if (rd_en) begin
            read_value_q <= rd_data;
        end
    end

    servo_seq_timer #(
        .TICK_CYCLES(TICK_CYCLES)
    ) u_timer (
        .clk   (clk),
        .reset (reset),
        .load  (ev_wr_done),
        .dwell (dwell_q),
        .enable(state_q == StDwell),
        .done  (tmr_done)
    );

    assign read_value_out        = read_value_q;
    assign ready_out             = sel_in;
    assign servo_address_out     = SERVO_ADDR;
    assign servo_write_value_out = {{(32 - PosWidth){1'b0}}, pos_q};
    assign step_monitor          = idx_q;

endmodule
